ibex_irq_ctrl: RTL and testbench
================================

IBEX_IRQ_CTRL -- requirements
Module: ibex_irq_ctrl

Interface
REQ-001 Parameter NUM_FAST, default 15, number of fast interrupt lines; legal range 1..15.
REQ-002 Parameter NEST_DEPTH, default 4, maximum number of nested taken interrupts; legal range 1..8.
REQ-003 Parameter RR_MODE, default 0, fast-line arbitration: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 clk_i  in  1  clock; all state updates on its rising edge.
REQ-006 rst_i  in  1  synchronous active-high reset.
REQ-007 irq_fast_i  in  NUM_FAST  level fast interrupt sources.
REQ-008 irq_fast_en_i  in  NUM_FAST  per-line enable mask.
REQ-009 irq_external_i / irq_software_i / irq_timer_i  in  1 each  level machine interrupt sources.
REQ-010 irq_nm_i  in  1  level non-maskable interrupt.
REQ-011 mstatus_mie_i  in  1  global enable for maskable interrupts.
REQ-012 debug_mode_i  in  1  core is in debug mode; blocks all requests.
REQ-013 irq_req_o  out  1  registered request to core controller.
REQ-014 irq_cause_o  out  6  cause for the current request; bit5 = 1, bits4:0 = code.
REQ-015 irq_ack_i  in  1  core accepted the request (sampled only while irq_req_o = 1).
REQ-016 mret_i  in  1  single-cycle pulse: innermost handler returned.
REQ-017 cur_cause_o  out  6  cause of the innermost active handler; 0 when nest_level_o = 0.
REQ-018 nest_level_o  out  clog2(NEST_DEPTH+1)  number of active handlers.
REQ-019 nmi_active_o  out  1  some active stack level was an NMI.
REQ-020 nest_full_o  out  1  nest_level_o == NEST_DEPTH.
REQ-021 ret_err_o  out  1  registered one-cycle pulse: mret_i received at nest_level_o = 0.

Function
REQ-022 Cause codes SHALL be: NMI 31, fast line k 16+k, external 11, software 3, timer 7.
REQ-023 Priority SHALL be NMI > fast > external > software > timer.
REQ-024 Within the fast group, RR_MODE=0 SHALL pick the highest pending index; RR_MODE=1 SHALL search upward from rr_ptr+1, wrapping modulo NUM_FAST.
REQ-025 rr_ptr SHALL update to the granted fast index only on an acknowledged fast request.
REQ-026 A maskable source is eligible iff it is asserted, enabled (fast lines only), mstatus_mie_i=1, debug_mode_i=0 and nest_full_o=0.
REQ-027 NMI is eligible iff irq_nm_i=1, debug_mode_i=0, nmi_active_o=0 and nest_full_o=0.
REQ-028 FSM states SHALL be IDLE and REQ.
REQ-029 IDLE: when any source is eligible at cycle N, go to REQ, latch the winning cause, and drive irq_req_o=1 from N+1.
REQ-030 REQ: irq_cause_o SHALL stay stable until acknowledged, except that an eligible NMI replaces a non-NMI cause on the next cycle while irq_req_o stays high.
REQ-031 REQ with irq_ack_i=1 at cycle M SHALL do all of the following, visible at M+1:
- drop irq_req_o;
- push the cause and an NMI flag onto the stack;
- increment nest_level_o;
- return to IDLE.
REQ-032 REQ with debug_mode_i=1 and no ack SHALL withdraw: irq_req_o=0 next cycle, return to IDLE, stack unchanged.
REQ-033 A request SHALL NOT be withdrawn because the source deasserted; the latched cause is kept until ack.
REQ-034 mret_i with nest_level_o>0 SHALL pop the top entry.
REQ-035 mret_i with nest_level_o=0 SHALL leave the state unchanged and pulse ret_err_o.
REQ-036 An ack and an mret_i in the same cycle SHALL perform the pop then the push: level unchanged, top entry replaced by the new cause.
REQ-037 nmi_active_o SHALL be the OR of the NMI flags of the active stack levels; popping the NMI level clears it.
REQ-038 The stack SHALL be NEST_DEPTH entries of 7 bits (cause plus NMI flag); unused entries read 0.
REQ-039 nest_level_o SHALL never exceed NEST_DEPTH and never go below 0.

Reset
REQ-040 With rst_i=1 at a clock edge the block SHALL take its reset state on that edge, from any state (including mid-request): state IDLE, irq_req_o=0, irq_cause_o=0, stack cleared, nest_level_o=0, cur_cause_o=0, nmi_active_o=0, ret_err_o=0, rr_ptr=NUM_FAST-1.
REQ-041 irq_ack_i and mret_i SHALL be ignored while rst_i=1.

Verification
REQ-042 The bench SHALL cover the following directed scenarios:
- Fixed priority: RR_MODE=0, MIE=1, fast[3], fast[9] and timer asserted -> irq_req_o high one cycle later, irq_cause_o=0x39 (fast 9); ack -> nest_level_o=1, cur_cause_o=0x39.
- Round-robin: RR_MODE=1, fast[2] and fast[5] held, ack then mret_i three times -> grant order 2, 5, 2.
- NMI preemption: fast[0] request pending unacked, irq_nm_i asserted -> cause goes 0x30 then 0x3F with irq_req_o held high; second NMI blocked until the NMI level is popped.
- Nesting limit: NEST_DEPTH=2, two acks -> nest_full_o=1 and no further request with sources held; one mret_i -> a request appears again.
- Simultaneous ack and mret_i at level 1 -> level stays 1, cur_cause_o becomes the new cause; mret_i at level 0 -> ret_err_o pulses for one cycle.
- Reset while irq_req_o=1 with a nonempty stack -> all outputs 0 on the next cycle.

Source files
------------

// File: rtl/ibex_irq_ctrl.sv
// ibex_irq_ctrl: interrupt arbiter with request/ack handshake and a nested-handler cause stack
module ibex_irq_ctrl #(
  parameter int NUM_FAST   = 15,
  parameter int NEST_DEPTH = 4,
  parameter bit RR_MODE    = 1'b0
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic [NUM_FAST-1:0]               irq_fast_i,
  input  logic [NUM_FAST-1:0]               irq_fast_en_i,
  input  logic                              irq_external_i,
  input  logic                              irq_software_i,
  input  logic                              irq_timer_i,
  input  logic                              irq_nm_i,
  input  logic                              mstatus_mie_i,
  input  logic                              debug_mode_i,
  output logic                              irq_req_o,
  output logic [5:0]                        irq_cause_o,
  input  logic                              irq_ack_i,
  input  logic                              mret_i,
  output logic [5:0]                        cur_cause_o,
  output logic [$clog2(NEST_DEPTH+1)-1:0]   nest_level_o,
  output logic                              nmi_active_o,
  output logic                              nest_full_o,
  output logic                              ret_err_o
);
  localparam int LW = $clog2(NEST_DEPTH + 1);
  localparam int FW = NUM_FAST > 1 ? $clog2(NUM_FAST) : 1;
  typedef enum logic {IDLE, REQ} state_e;
  state_e                      state;
  logic [FW-1:0]               rr_ptr, fast_idx, cf;
  logic [NEST_DEPTH-1:0][6:0]  stk;
  logic [NUM_FAST-1:0]         fast_pend;
  logic                        mask_ok, nmi_ok, any_elig, push, pop, is_fast;
  logic [4:0]                  win;
  logic [LW-1:0]               lvl_base;
  int                          c;
  assign nest_full_o = nest_level_o == LW'(NEST_DEPTH);
  assign mask_ok     = mstatus_mie_i & ~debug_mode_i & ~nest_full_o;
  assign nmi_ok      = irq_nm_i & ~debug_mode_i & ~nmi_active_o & ~nest_full_o;
  assign fast_pend   = irq_fast_i & irq_fast_en_i & {NUM_FAST{mask_ok}};
  assign any_elig    = nmi_ok | (|fast_pend) |
                       (mask_ok & (irq_external_i | irq_software_i | irq_timer_i));
  assign win = nmi_ok                         ? 5'd31 :
               |fast_pend                     ? 5'd16 + 5'(fast_idx) :
               mask_ok & irq_external_i       ? 5'd11 :
               mask_ok & irq_software_i       ? 5'd3  : 5'd7;
  assign push     = state == REQ && irq_ack_i;
  assign pop      = mret_i && nest_level_o != '0;
  assign lvl_base = nest_level_o - LW'(pop);
  assign is_fast  = irq_cause_o[4] && irq_cause_o != 6'h3f;
  // Search order position 1 has top priority, so the last match in a descending scan wins
  always_comb begin
    fast_idx = '0;
    c = 0;
    cf = '0;
    for (int i = NUM_FAST; i >= 1; i--) begin
      c = RR_MODE ? (int'(rr_ptr) + i) % NUM_FAST : NUM_FAST - i;
      cf = FW'(c);
      if (fast_pend[cf]) fast_idx = cf;
    end
  end
  // Unused stack entries hold zero, so the NMI flag can be ORed over the whole stack
  always_comb begin
    cur_cause_o = '0;
    nmi_active_o = 1'b0;
    for (int j = 0; j < NEST_DEPTH; j++) begin
      nmi_active_o = nmi_active_o | stk[j][6];
      if (nest_level_o == LW'(j + 1)) cur_cause_o = stk[j][5:0];
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      irq_req_o <= 1'b0;
      irq_cause_o <= '0;
      stk <= '0;
      nest_level_o <= '0;
      ret_err_o <= 1'b0;
      rr_ptr <= FW'(NUM_FAST - 1);
    end else begin
      ret_err_o <= mret_i && nest_level_o == '0;
      nest_level_o <= push ? lvl_base + LW'(1) : lvl_base;
      for (int j = 0; j < NEST_DEPTH; j++) begin
        if (push && LW'(j) == lvl_base) stk[j] <= {irq_cause_o == 6'h3f, irq_cause_o};
        else if (pop && LW'(j + 1) == nest_level_o) stk[j] <= '0;
      end
      if (state == IDLE) begin
        if (any_elig) begin
          state <= REQ;
          irq_req_o <= 1'b1;
          irq_cause_o <= {1'b1, win};
        end
      end else if (irq_ack_i) begin
        state <= IDLE;
        irq_req_o <= 1'b0;
        if (is_fast) rr_ptr <= FW'(irq_cause_o[3:0]);
      end else if (debug_mode_i) begin
        state <= IDLE;
        irq_req_o <= 1'b0;
      end else if (nmi_ok) irq_cause_o <= 6'h3f;
    end
  end
endmodule

// File: tb/tb_ibex_irq_ctrl.sv
// tb_ibex_irq_ctrl: directed vector table on a fixed-priority instance plus round-robin and nesting sequences
module tb_ibex_irq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1, ext = 1'b0, sw = 1'b0, tmr = 1'b0, nm = 1'b0, mie = 1'b0, dbg = 1'b0;
  logic ack = 1'b0, mret = 1'b0;
  logic [14:0] fast = '0, en = '0;
  logic       r0, r1, r2, n0, n1, n2, f0, f1, f2, e0, e1, e2;
  logic [5:0] c0, c1, c2, k0, k1, k2;
  logic [2:0] l0, l1;
  logic [1:0] l2;
  int checks = 0, failures = 0;
  ibex_irq_ctrl #(.RR_MODE(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .irq_fast_i(fast), .irq_fast_en_i(en), .irq_external_i(ext),
    .irq_software_i(sw), .irq_timer_i(tmr), .irq_nm_i(nm), .mstatus_mie_i(mie),
    .debug_mode_i(dbg), .irq_req_o(r0), .irq_cause_o(c0), .irq_ack_i(ack), .mret_i(mret),
    .cur_cause_o(k0), .nest_level_o(l0), .nmi_active_o(n0), .nest_full_o(f0), .ret_err_o(e0));
  ibex_irq_ctrl #(.RR_MODE(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .irq_fast_i(fast), .irq_fast_en_i(en), .irq_external_i(ext),
    .irq_software_i(sw), .irq_timer_i(tmr), .irq_nm_i(nm), .mstatus_mie_i(mie),
    .debug_mode_i(dbg), .irq_req_o(r1), .irq_cause_o(c1), .irq_ack_i(ack), .mret_i(mret),
    .cur_cause_o(k1), .nest_level_o(l1), .nmi_active_o(n1), .nest_full_o(f1), .ret_err_o(e1));
  ibex_irq_ctrl #(.NEST_DEPTH(2)) u2 (
    .clk_i(clk), .rst_i(rst), .irq_fast_i(fast), .irq_fast_en_i(en), .irq_external_i(ext),
    .irq_software_i(sw), .irq_timer_i(tmr), .irq_nm_i(nm), .mstatus_mie_i(mie),
    .debug_mode_i(dbg), .irq_req_o(r2), .irq_cause_o(c2), .irq_ack_i(ack), .mret_i(mret),
    .cur_cause_o(k2), .nest_level_o(l2), .nmi_active_o(n2), .nest_full_o(f2), .ret_err_o(e2));
  typedef struct {
    int rst, fast, en, ext, sw, tmr, nm, mie, dbg, ack, mret;
    int req, cause, cc, lvl, cur, nmi, full, rerr;
  } vec_t;
  vec_t vq[$];
  vec_t v;
  task automatic chk(input string nm_s, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm_s, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    {ext, sw, tmr, nm, mie, dbg, ack, mret} = '0;
    fast = '0;
    en = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask
  initial begin
    // rst fast en ext sw tmr nm mie dbg ack mret | req cause cc lvl cur nmi full rerr
    vq.push_back('{1, 0,      'h7fff, 0,0,0,0,0,0,0,0, 0,'h00,1,0,'h00,0,0,0});
    vq.push_back('{0, 'h0208, 'h7fff, 0,0,1,0,1,0,0,0, 1,'h39,1,0,'h00,0,0,0});
    vq.push_back('{0, 'h0208, 'h7fff, 0,0,1,0,1,0,1,0, 0,'h00,0,1,'h39,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,1,0,1,0,0,0, 1,'h27,1,1,'h39,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,1,0,1,0,1,1, 0,'h00,0,1,'h27,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,0,1,0,0,1, 0,'h00,0,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,0,1,0,0,1, 0,'h00,0,0,'h00,0,0,1});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,0,1,0,0,0, 0,'h00,0,0,'h00,0,0,0});
    vq.push_back('{0, 'h0001, 'h7fff, 0,0,0,0,1,0,0,0, 1,'h30,1,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,1,1,0,0,0, 1,'h3f,1,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,1,1,0,1,0, 0,'h00,0,1,'h3f,1,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,1,1,0,0,0, 0,'h00,0,1,'h3f,1,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,1,1,0,0,1, 0,'h00,0,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,1,1,0,0,0, 1,'h3f,1,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 0,0,0,0,1,0,1,0, 0,'h00,0,1,'h3f,1,0,0});
    vq.push_back('{0, 0,      'h7fff, 1,0,0,0,1,0,0,0, 1,'h2b,1,1,'h3f,1,0,0});
    vq.push_back('{1, 0,      'h7fff, 1,0,0,0,1,0,1,1, 0,'h00,1,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 1,0,0,0,0,0,0,0, 0,'h00,0,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 1,0,0,0,1,1,0,0, 0,'h00,0,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 1,0,0,0,1,0,0,0, 1,'h2b,1,0,'h00,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 1,0,0,0,1,1,0,0, 0,'h00,0,0,'h00,0,0,0});
    vq.push_back('{0, 'h7fff, 0,      0,1,1,0,1,0,0,0, 1,'h23,1,0,'h00,0,0,0});
    vq.push_back('{0, 'h7fff, 0,      0,1,1,0,1,0,1,0, 0,'h00,0,1,'h23,0,0,0});
    vq.push_back('{0, 0,      'h7fff, 1,1,0,0,1,0,0,0, 1,'h2b,1,1,'h23,0,0,0});
    #1;
    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rst = v.rst != 0; fast = 15'(v.fast); en = 15'(v.en);
      ext = v.ext != 0; sw = v.sw != 0; tmr = v.tmr != 0; nm = v.nm != 0;
      mie = v.mie != 0; dbg = v.dbg != 0; ack = v.ack != 0; mret = v.mret != 0;
      tick();
      chk($sformatf("v%0d_req", i), int'(r0), v.req);
      if (v.cc != 0) chk($sformatf("v%0d_cause", i), int'(c0), v.cause);
      chk($sformatf("v%0d_level", i), int'(l0), v.lvl);
      chk($sformatf("v%0d_cur", i), int'(k0), v.cur);
      chk($sformatf("v%0d_nmi", i), int'(n0), v.nmi);
      chk($sformatf("v%0d_full", i), int'(f0), v.full);
      chk($sformatf("v%0d_reterr", i), int'(e0), v.rerr);
    end
    do_reset();
    fast = 15'h0024;
    en = 15'h7fff;
    mie = 1'b1;
    for (int g = 0; g < 3; g++) begin
      int t;
      int ord;
      t = 0;
      ord = (g == 1) ? 5 : 2;
      while (!r1 && t < 20) begin
        tick();
        t++;
      end
      chk($sformatf("rr%0d_req", g), int'(r1), 1);
      chk($sformatf("rr%0d_grant", g), int'(c1), 'h30 + ord);
      ack = 1'b1; tick(); ack = 1'b0;
      chk($sformatf("rr%0d_lvl_ack", g), int'(l1), 1);
      chk($sformatf("rr%0d_cur", g), int'(k1), 'h30 + ord);
      mret = 1'b1; tick(); mret = 1'b0;
      chk($sformatf("rr%0d_lvl_mret", g), int'(l1), 0);
    end
    do_reset();
    ext = 1'b1;
    mie = 1'b1;
    for (int g = 0; g < 2; g++) begin
      int t;
      t = 0;
      while (!r2 && t < 20) begin
        tick();
        t++;
      end
      chk($sformatf("nest%0d_req", g), int'(r2), 1);
      ack = 1'b1; tick(); ack = 1'b0;
    end
    chk("nest_level_full", int'(l2), 2);
    chk("nest_full_flag", int'(f2), 1);
    for (int t = 0; t < 4; t++) begin
      tick();
      chk($sformatf("nest_blocked%0d", t), int'(r2), 0);
    end
    mret = 1'b1; tick(); mret = 1'b0;
    chk("nest_level_pop", int'(l2), 1);
    chk("nest_full_clear", int'(f2), 0);
    tick();
    chk("nest_req_again", int'(r2), 1);
    chk("nest_req_cause", int'(c2), 'h2b);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
